mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data access.
// Data wins ties; one transaction in flight, aborted after TIMEOUT_CYC waits.
module mem_arbiter #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ice,
    input  logic [31:0] iaddr,
    output logic [31:0] inst,
    input  logic        dce,
    input  logic [31:0] daddr,
    input  logic [3:0]  we,
    input  logic [31:0] din,
    output logic [31:0] dm,
    input  logic        flush,
    output logic        ram_ce,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_we,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    input  logic        ram_ack,
    output logic        stallreq_arb,
    output logic        bus_err
);

    typedef enum logic [1:0] {IDLE, D_WAIT, I_WAIT} state_t;

    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYC - 1);

    state_t     state;
    state_t     state_nx;
    logic       d_done;
    logic       i_done;
    logic       drop;
    logic [7:0] wait_cnt;
    logic       issue_d;
    logic       issue_i;
    logic       fin;
    logic       tmo;

    assign stallreq_arb = (dce & ~d_done) | (ice & ~i_done);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        issue_d  = 1'b0;
        issue_i  = 1'b0;
        fin      = 1'b0;
        tmo      = 1'b0;
        unique case (state)
            IDLE: begin
                if (dce && !d_done) begin
                    issue_d  = 1'b1;
                    state_nx = D_WAIT;
                end else if (ice && !i_done && !flush) begin
                    issue_i  = 1'b1;
                    state_nx = I_WAIT;
                end
            end
            D_WAIT, I_WAIT: begin
                // an ack in the final wait cycle beats the timeout
                if (ram_ack) begin
                    fin      = 1'b1;
                    state_nx = IDLE;
                end else if (wait_cnt == LAST_WAIT) begin
                    tmo      = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ram_ce    <= 1'b0;
            ram_addr  <= 32'h0;
            ram_we    <= 4'h0;
            ram_wdata <= 32'h0;
            inst      <= 32'h0;
            dm        <= 32'h0;
            d_done    <= 1'b0;
            i_done    <= 1'b0;
            wait_cnt  <= 8'h0;
            bus_err   <= 1'b0;
            drop      <= 1'b0;
        end else begin
            bus_err <= 1'b0;
            // pipeline advanced: forget completions so new requests issue
            if (!stallreq_arb) begin
                d_done <= 1'b0;
                i_done <= 1'b0;
            end
            drop <= (state == I_WAIT) && (state_nx == I_WAIT) && (drop || flush);
            if (issue_d) begin
                ram_ce    <= 1'b1;
                ram_addr  <= daddr;
                ram_we    <= we;
                ram_wdata <= din;
                wait_cnt  <= 8'h0;
            end else if (issue_i) begin
                ram_ce   <= 1'b1;
                ram_addr <= iaddr;
                ram_we   <= 4'h0;
                wait_cnt <= 8'h0;
            end else if (fin) begin
                ram_ce   <= 1'b0;
                wait_cnt <= 8'h0;
                if (state == D_WAIT) begin
                    if (ram_we == 4'h0) dm <= ram_rdata;
                    d_done <= 1'b1;
                end else if (!(drop || flush)) begin
                    inst   <= ram_rdata;
                    i_done <= 1'b1;
                end
            end else if (tmo) begin
                ram_ce   <= 1'b0;
                bus_err  <= 1'b1;
                wait_cnt <= 8'h0;
                if (state == D_WAIT) begin
                    dm     <= 32'h0;
                    d_done <= 1'b1;
                end else begin
                    inst   <= 32'h0;
                    i_done <= 1'b1;
                end
            end else if (state != IDLE) begin
                wait_cnt <= wait_cnt + 8'h1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: RAM responder plus transaction-level
// model of request ordering, results, flush retries and timeouts.
module tb_mem_arbiter;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ice;
    logic [31:0] iaddr;
    logic [31:0] inst;
    logic        dce;
    logic [31:0] daddr;
    logic [3:0]  we;
    logic [31:0] din;
    logic [31:0] dm;
    logic        flush;
    logic        ram_ce;
    logic [31:0] ram_addr;
    logic [3:0]  ram_we;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ack;
    logic        stallreq_arb;
    logic        bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst),
        .ice(ice), .iaddr(iaddr), .inst(inst),
        .dce(dce), .daddr(daddr), .we(we), .din(din), .dm(dm),
        .flush(flush),
        .ram_ce(ram_ce), .ram_addr(ram_addr), .ram_we(ram_we),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .ram_ack(ram_ack),
        .stallreq_arb(stallreq_arb), .bus_err(bus_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        bit          is_d;
        int          lat;
        int          fl;
    } txn_t;

    txn_t        q[$];
    logic [31:0] rd_pat[$];
    logic [31:0] exp_dm;
    logic [31:0] exp_inst;
    int          ce_cnt;
    int          st_cnt;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ice = 1'b0; dce = 1'b0; flush = 1'b0; ram_ack = 1'b0;
        iaddr = 32'h0; daddr = 32'h0; we = 4'h0; din = 32'h0;
        ram_rdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_dm = 32'h0;
        exp_inst = 32'h0;
    endtask

    // Drive one pipeline request set and serve the RAM until it retires.
    task automatic run_op(input bit do_d, input logic [31:0] da,
                          input logic [3:0] dwe, input logic [31:0] dd,
                          input int lat_d, input bit do_i,
                          input logic [31:0] ia, input int lat_i,
                          input int fl);
        txn_t t;
        txn_t cur;
        bit busy = 0, done = 0, early = 0, chk_drop = 0;
        int k = 0, errs = 0, exp_errs = 0, cyc = 0;
        logic [31:0] rd;
        q.delete();
        ce_cnt = 0;
        st_cnt = 0;
        if (do_d) begin
            t = '{da, dwe, dd, 1'b1, lat_d, -1};
            q.push_back(t);
        end
        if (do_i) begin
            t = '{ia, 4'h0, 32'h0, 1'b0, lat_i, fl};
            q.push_back(t);
        end
        dce = do_d; daddr = da; we = dwe; din = dd;
        ice = do_i; iaddr = ia;
        while (!done && cyc < 100) begin
            @(posedge clk);
            @(negedge clk);
            cyc++;
            ram_ack = 1'b0;
            flush = 1'b0;
            if (bus_err) errs++;
            if (ram_ce) ce_cnt++;
            if (stallreq_arb) st_cnt++;
            if (chk_drop) begin
                check("ce_drop_after_ack", 32'(ram_ce), 32'h0);
                chk_drop = 0;
            end
            if (busy) begin
                if (!ram_ce) begin
                    check("timeout_expected", 32'(cur.lat >= T), 32'h1);
                    check("ce_high_cycles", k + 1, T);
                    if (cur.is_d) exp_dm = 32'h0;
                    else exp_inst = 32'h0;
                    exp_errs++;
                    busy = 0;
                    if (cur.lat == T) begin
                        ram_ack = 1'b1;
                        ram_rdata = $urandom;
                    end
                end else begin
                    k++;
                    check("addr_stable", ram_addr, cur.addr);
                    check("we_stable", 32'(ram_we), 32'(cur.we));
                    if (cur.is_d)
                        check("wdata_stable", ram_wdata, cur.wdata);
                end
            end else if (ram_ce) begin
                if (q.size() == 0) begin
                    check("unexpected_txn", 32'h1, 32'h0);
                end else begin
                    cur = q.pop_front();
                    busy = 1;
                    k = 0;
                    check("req_addr", ram_addr, cur.addr);
                    check("req_we", 32'(ram_we), 32'(cur.we));
                    if (cur.is_d)
                        check("req_wdata", ram_wdata, cur.wdata);
                end
            end
            if (busy && ram_ce) begin
                if (!cur.is_d && cur.fl == k) flush = 1'b1;
                if (k == cur.lat) begin
                    if (rd_pat.size() > 0) rd = rd_pat.pop_front();
                    else rd = $urandom;
                    ram_ack = 1'b1;
                    ram_rdata = rd;
                    busy = 0;
                    chk_drop = 1;
                    if (cur.is_d) begin
                        if (cur.we == 4'h0) exp_dm = rd;
                    end else if (cur.fl >= 0) begin
                        t = cur;
                        t.fl = -1;
                        t.lat = 1;
                        q.push_back(t);
                    end else begin
                        exp_inst = rd;
                    end
                end
            end
            if (!stallreq_arb && (busy || q.size() != 0)) early = 1;
            if (!busy && q.size() == 0 && !stallreq_arb) done = 1;
        end
        check("op_done", 32'(done), 32'h1);
        dce = 1'b0;
        ice = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ram_ack = 1'b0;
        flush = 1'b0;
        if (bus_err) errs++;
        check("stall_early", 32'(early), 32'h0);
        check("stall_idle", 32'(stallreq_arb), 32'h0);
        check("dm", dm, exp_dm);
        check("inst", inst, exp_inst);
        check("bus_err_pulses", errs, exp_errs);
    endtask

    initial begin
        bit          use_d;
        bit          use_i;
        int          sel;
        int          ld;
        int          li;
        int          fl;
        logic [3:0]  w;

        do_reset();
        check("rst_ram_ce", 32'(ram_ce), 32'h0);
        check("rst_ram_addr", ram_addr, 32'h0);
        check("rst_ram_we", 32'(ram_we), 32'h0);
        check("rst_ram_wdata", ram_wdata, 32'h0);
        check("rst_inst", inst, 32'h0);
        check("rst_dm", dm, 32'h0);
        check("rst_bus_err", 32'(bus_err), 32'h0);
        check("rst_stall", 32'(stallreq_arb), 32'h0);

        rd_pat.push_back(32'h24010005);
        run_op(0, 32'h0, 4'h0, 32'h0, 1, 1, 32'h40, 1, -1);
        check("fetch_stall_cycles", st_cnt, 2);
        check("fetch_inst", inst, 32'h24010005);

        run_op(1, 32'h100, 4'hF, 32'hDEADBEEF, 1, 1, 32'h44, 1, -1);

        rd_pat.push_back(32'h12345678);
        run_op(1, 32'h200, 4'h0, 32'h0, 3, 0, 32'h0, 1, -1);
        check("load_ce_cycles", ce_cnt, 4);
        check("load_dm", dm, 32'h12345678);

        run_op(0, 32'h0, 4'h0, 32'h0, 1, 1, 32'h80, 2, 1);
        run_op(0, 32'h0, 4'h0, 32'h0, 1, 1, 32'h84, 2, 2);

        run_op(1, 32'h300, 4'h0, 32'h0, 6, 0, 32'h0, 1, -1);
        check("tmo_ce_cycles", ce_cnt, 4);
        run_op(0, 32'h0, 4'h0, 32'h0, 1, 1, 32'h88, T, -1);
        run_op(1, 32'h304, 4'h3, 32'h55AA55AA, T, 1, 32'h8C, 1, -1);

        dce = 1'b1; daddr = 32'h400; we = 4'h0;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_ce", 32'(ram_ce), 32'h1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        dce = 1'b0;
        ram_ack = 1'b1;
        ram_rdata = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        ram_ack = 1'b0;
        check("mid_rst_ce", 32'(ram_ce), 32'h0);
        check("mid_rst_addr", ram_addr, 32'h0);
        check("mid_rst_we", 32'(ram_we), 32'h0);
        check("mid_rst_dm", dm, 32'h0);
        check("mid_rst_inst", inst, 32'h0);
        check("mid_rst_bus_err", 32'(bus_err), 32'h0);
        exp_dm = 32'h0;
        exp_inst = 32'h0;

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 2);
            use_d = (sel != 1);
            use_i = (sel != 0);
            if ($urandom_range(0, 1) == 1) w = 4'h0;
            else w = 4'($urandom);
            ld = $urandom_range(1, 5);
            li = $urandom_range(1, 5);
            fl = -1;
            if (li < T && $urandom_range(0, 3) == 0)
                fl = $urandom_range(0, li);
            run_op(use_d, $urandom, w, $urandom, ld,
                   use_i, $urandom, li, fl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
